// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file write-back initiator.
package rf_wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    STALL
  } wb_state_t;

  // x0 is hard-wired zero, so it never contributes to a pending-write mask.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    logic [NREGS-1:0] m;
    m = '0;
    if (r != '0) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular buffer of pending write-back entries; exports every slot in age
// order (index 0 = head) with a valid bit for hazard and forwarding lookups.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  wb_entry_t                push_entry_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output wb_entry_t                head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output wb_entry_t [DEPTH-1:0]    entries_o,
  output logic [DEPTH-1:0]         valid_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  wb_entry_t     mem_q [DEPTH];
  logic          do_push, do_pop;

  assign do_push = push_i & ~flush_i & (count_q != CW'(DEPTH));
  assign do_pop  = pop_i & ~flush_i & (count_q != '0);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; slot contents only matter where the count marks them valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx          = rd_ptr_q + PW'(k);
      entries_o[k] = mem_q[idx];
      valid_o[k]   = CW'(k) < count_q;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rf_writeback.sv
// Register-file write-back initiator: buffers results, issues one registered
// write per cycle and exports a pending-write mask for RAW stalls.
// Optional build macro RF_WB_FWD_EN adds two combinational forwarding ports.
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [REG_AW-1:0] res_rd,
  input  logic [XLEN-1:0]   res_data,
  input  logic              wb_stall,
  input  logic              flush,
  output logic              RegWrite,
  output logic [REG_AW-1:0] waddr,
  output logic [XLEN-1:0]   wdata,
  output logic [NREGS-1:0]  busy_mask,
  output logic              empty
`ifdef RF_WB_FWD_EN
  ,
  input  logic [REG_AW-1:0] fwd_raddr1,
  input  logic [REG_AW-1:0] fwd_raddr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [XLEN-1:0]   fwd_data1,
  output logic [XLEN-1:0]   fwd_data2
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_state_t             state_q, state_d;
  logic                  push, pop, last_entry;
  logic [CW-1:0]         count;
  wb_entry_t             head, push_entry;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic                  regwrite_q;
  logic [REG_AW-1:0]     waddr_q;
  logic [XLEN-1:0]       wdata_q;

  // x0 results complete the handshake but are never stored.
  assign res_ready  = count != CW'(DEPTH);
  assign push       = res_valid & res_ready & (res_rd != '0);
  assign push_entry = '{rd: res_rd, data: res_data};
  assign last_entry = count == CW'(1);

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (Clk),
    .rst_n        (Rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (flush),
    .head_o       (head),
    .count_o      (count),
    .entries_o    (entries),
    .valid_o      (valid)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (push) state_d = ISSUE;
        ISSUE: begin
          if (wb_stall)                state_d = STALL;
          else if (last_entry && !push) state_d = IDLE;
        end
        STALL: begin
          if (!wb_stall) state_d = (last_entry && !push) ? IDLE : ISSUE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Non-IDLE states always hold at least one entry, so the state alone gates issue.
  always_comb begin
    pop = (state_q != IDLE) & ~wb_stall & ~flush;
  end

  // Write port is registered so the regfile's negedge write sees stable values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      regwrite_q <= pop;
      if (pop) begin
        waddr_q <= head.rd;
        wdata_q <= head.data;
      end
    end
  end

  assign RegWrite = regwrite_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign empty    = (count == '0) & ~regwrite_q;

  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid[k]) busy_mask |= reg_onehot(entries[k].rd);
    end
    if (regwrite_q) busy_mask |= reg_onehot(waddr_q);
  end

`ifdef RF_WB_FWD_EN
  // Youngest match wins: the port register is oldest, then FIFO head to tail.
  function automatic logic [XLEN:0] fwd_lookup(input logic [REG_AW-1:0] raddr);
    logic            hit;
    logic [XLEN-1:0] data;
    hit  = regwrite_q && (waddr_q == raddr);
    data = wdata_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid[k] && entries[k].rd == raddr) begin
        hit  = 1'b1;
        data = entries[k].data;
      end
    end
    if (raddr == '0) hit = 1'b0;
    return {hit, data};
  endfunction

  always_comb begin
    {fwd_hit1, fwd_data1} = fwd_lookup(fwd_raddr1);
    {fwd_hit2, fwd_data2} = fwd_lookup(fwd_raddr2);
  end
`else
  logic unused_entry_data;
  assign unused_entry_data = ^entries;
`endif

endmodule
